// File: rtl/dm_bus_responder.sv
// dm_bus_responder: data-memory responder for the CPU load/store port.
// Takes one request at a time and holds it for LATENCY cycles. It then does a
// byte-enabled write or a whole-word read and presents the response until the
// core takes it. Byte/halfword extraction for loads is left to the core.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready.
// A response transfers on a rising edge where resp_valid & resp_ready.
// resp_rdata and resp_err hold steady for as long as resp_valid is high.
// The responder raises req_ready only in the cycle after a response has
// transferred, so it never re-accepts in the same cycle.
//
// Committed writes are also reported on the log* outputs, as a one-cycle
// pulse. The pulse carries the issuing PC, the word-aligned address and the
// merged word, so a bench or trace unit can print the write log.
module dm_bus_responder #(
  parameter int          DEPTH_WORDS = 3072,
  parameter logic [31:0] BASE_ADDR   = 32'h00000000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byteen,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        logValid,
  output logic [31:0] logPc,
  output logic [31:0] logAddr,
  output logic [31:0] logData,
  output logic [1:0]  dbgState
);

  localparam int          IDXW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];
  // WAIT spends CNT_LOAD+1 cycles, so LATENCY-2 lines up the response edge.
  localparam logic [3:0]  CNT_LOAD  = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateT;

  stateT       state;
  logic [3:0]  cnt;

  // Captured request; the address is kept as a word address.
  logic        capWe;
  logic [29:0] capWord;
  logic [3:0]  capBe;
  logic [31:0] capWdata;
  logic [31:0] capPc;

  logic [31:0] mem [DEPTH_WORDS];

  logic [29:0]     wordOff;
  logic            inRange;
  logic [IDXW-1:0] idx;
  logic [31:0]     curWord;
  logic [31:0]     mergedWord;
  logic            doAccess;
  logic            doWrite;

  assign dbgState = state;

  // Address decode, byte merge and access strobes for the captured request
  always_comb begin
    wordOff    = capWord - BASE_WORD;
    inRange    = (capWord >= BASE_WORD) && ({2'b00, wordOff} < 32'(DEPTH_WORDS));
    idx        = wordOff[IDXW-1:0];
    curWord    = inRange ? mem[idx] : 32'h0;
    mergedWord = curWord;
    for (int b = 0; b < 4; b++) begin
      if (capBe[b]) mergedWord[8*b +: 8] = capWdata[8*b +: 8];
    end
    // The access happens once, on the first RESP edge, while resp_valid is still low.
    doAccess = (state == RESP) && !resp_valid;
    doWrite  = doAccess && capWe && inRange && (capBe != 4'b0000);
  end

  // Storage: cleared by reset, updated only by a committed in-range write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'h0;
    end else if (doWrite) begin
      mem[idx] <= mergedWord;
    end
  end

  // Control FSM with registered handshake, response and log outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      capWe      <= 1'b0;
      capWord    <= 30'h0;
      capBe      <= 4'h0;
      capWdata   <= 32'h0;
      capPc      <= 32'h0;
      logValid   <= 1'b0;
      logPc      <= 32'h0;
      logAddr    <= 32'h0;
      logData    <= 32'h0;
    end else begin
      logValid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            capWe     <= req_we;
            capWord   <= req_addr[31:2];
            capBe     <= req_byteen;
            capWdata  <= req_wdata;
            capPc     <= req_pc;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_LOAD;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (doAccess) begin
            resp_valid <= 1'b1;
            resp_err   <= !inRange;
            resp_rdata <= (!capWe && inRange) ? curWord : 32'h0;
            if (doWrite) begin
              logValid <= 1'b1;
              logPc    <= capPc;
              logAddr  <= {capWord, 2'b00};
              logData  <= mergedWord;
            end
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_bus_responder.sv
// tb_dm_bus_responder: directed bench for dm_bus_responder (LATENCY=2, 3072 words).
module tb_dm_bus_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [3:0]  req_byteen = 4'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        logValid;
  logic [31:0] logPc;
  logic [31:0] logAddr;
  logic [31:0] logData;
  logic [1:0]  dbgState;

  int total = 0;
  int bad = 0;

  logic [32:0] exp_q[$];   // {err, rdata}
  logic [95:0] log_q[$];   // {pc, addr, data}
  logic [31:0] model [0:3071];

  dm_bus_responder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_wdata(req_wdata), .req_pc(req_pc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .logValid(logValid), .logPc(logPc), .logAddr(logAddr), .logData(logData),
    .dbgState(dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3072; i++) model[i] = 32'h0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // driver: wait for req_ready, present one request for exactly one accept edge
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] pc);
    int n;
    logic [31:0] idx;
    logic        err;
    logic [31:0] merged;
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL issue_timeout: req_ready got 0, required 1");
      return;
    end
    idx = addr >> 2;
    err = (idx >= 32'd3072);
    if (err) begin
      exp_q.push_back({1'b1, 32'h0});
    end else if (!we) begin
      exp_q.push_back({1'b0, model[idx]});
    end else begin
      merged = model[idx];
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
      exp_q.push_back({1'b0, 32'h0});
      if (be != 4'b0000) begin
        model[idx] = merged;
        log_q.push_back({pc, {addr[31:2], 2'b00}, merged});
      end
    end
    req_we = we; req_addr = addr; req_byteen = be; req_wdata = wd; req_pc = pc;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (exp_q.size() != 0 || !req_ready) begin
      bad++;
      $display("FAIL idle_timeout: pending=%0d req_ready=%0b, required 0 and 1", exp_q.size(), req_ready);
    end
  endtask

  // scoreboard monitor: responses
  always @(negedge clk) begin
    logic [32:0] e;
    if (!reset && resp_valid && resp_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected: got err=%0b rdata=%h, required no response", resp_err, resp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({resp_err, resp_rdata} !== e) begin
          bad++;
          $display("FAIL resp: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   resp_err, resp_rdata, e[32], e[31:0]);
        end
      end
    end
  end

  // scoreboard monitor: write log
  always @(negedge clk) begin
    logic [95:0] e;
    if (!reset && logValid) begin
      $display("%0t@%h: *%h <= %h", $time, logPc, logAddr, logData);
      total++;
      if (log_q.size() == 0) begin
        bad++;
        $display("FAIL log_unexpected: got pc=%h addr=%h data=%h, required no log", logPc, logAddr, logData);
      end else begin
        e = log_q.pop_front();
        if ({logPc, logAddr, logData} !== e) begin
          bad++;
          $display("FAIL log: got %h/%h/%h, required %h/%h/%h",
                   logPc, logAddr, logData, e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int n;
    do_reset();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_state", 32'(dbgState), 32'd0);

    // first read: valid must rise exactly two edges after the accept edge
    issue(1'b0, 32'h0000, 4'h0, 32'h0, 32'h0);
    check("lat_t0", 32'(resp_valid), 32'd0);
    check("lat_t0_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check("lat_t1", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_t2", 32'(resp_valid), 32'd1);
    wait_idle();

    // full write, readback, partial merge, zero-enable write
    issue(1'b1, 32'h0010, 4'b1111, 32'h12345678, 32'h3000);
    issue(1'b0, 32'h0010, 4'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h0012, 4'b1100, 32'hAABB0000, 32'h3004);
    issue(1'b0, 32'h0010, 4'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h0010, 4'b0000, 32'hFFFFFFFF, 32'h3008);
    issue(1'b0, 32'h0010, 4'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h0014, 4'b0101, 32'h11223344, 32'h300C);
    issue(1'b0, 32'h0014, 4'h0, 32'h0, 32'h0);
    wait_idle();

    // backpressure: response holds while resp_ready is low
    resp_ready = 1'b0;
    issue(1'b0, 32'h0010, 4'h0, 32'h0, 32'h0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, 32'hAABB5678);
      check("hold_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("release_req_ready", 32'(req_ready), 32'd1);
    check("release_valid", 32'(resp_valid), 32'd0);
    check("release_state", 32'(dbgState), 32'd0);
    wait_idle();

    // range boundary: last word valid, index 3072 errors
    issue(1'b1, 32'h2FFC, 4'b1111, 32'hCAFEF00D, 32'h3010);
    issue(1'b0, 32'h2FFC, 4'h0, 32'h0, 32'h0);
    issue(1'b0, 32'h3000, 4'h0, 32'h0, 32'h0);
    issue(1'b1, 32'h3000, 4'b1111, 32'h55555555, 32'h3014);
    issue(1'b0, 32'h2FFC, 4'h0, 32'h0, 32'h0);
    issue(1'b0, 32'hFFFF_FFFC, 4'h0, 32'h0, 32'h0);
    wait_idle();

    // reset during WAIT of a write drops it
    req_we = 1'b1; req_addr = 32'h0020; req_byteen = 4'b1111;
    req_wdata = 32'hDEADBEEF; req_pc = 32'h3020;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midrst_in_wait", 32'(dbgState), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3072; i++) model[i] = 32'h0;
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_valid", 32'(resp_valid), 32'd0);
    repeat (4) @(posedge clk);
    #1 check("midrst_valid_later", 32'(resp_valid), 32'd0);
    issue(1'b0, 32'h0020, 4'h0, 32'h0, 32'h0);
    issue(1'b0, 32'h0010, 4'h0, 32'h0, 32'h0);
    wait_idle();

    check("log_queue_drained", 32'(log_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
